// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerator result-drain path.
// Holds the default geometry, the drain FSM state encoding and a tile-count clamp helper.
package accel_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 7;
    localparam int TILE_ELEMS = 16;
    localparam int MAX_TILES  = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    // Limit a requested tile count to what the output memory can hold.
    function automatic logic [3:0] clamp_tiles(input logic [3:0] req, input logic [3:0] max_tiles);
        logic [3:0] n_s;
        if (req > max_tiles) begin
            n_s = max_tiles;
        end else begin
            n_s = req;
        end
        return n_s;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous first-word-fall-through FIFO used as the drain output skid buffer.
// Head entry is visible on rdata whenever empty is low; push and pop may coincide when full.
module drain_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty   = (count_r == {CW{1'b0}});
    assign full    = (count_r == CW'(DEPTH));
    assign count   = count_r;
    assign rdata   = mem_r[rd_ptr_r];
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/result_drain.sv
// Reads num_tiles x TILE_ELEMS words from the output memory's registered read port and
// streams them out on a valid/ready interface tagged with index, tile-end and last markers.
module result_drain #(
    parameter int DATA_W     = accel_pkg::DATA_W,
    parameter int ADDR_W     = accel_pkg::ADDR_W,
    parameter int TILE_ELEMS = accel_pkg::TILE_ELEMS,
    parameter int MAX_TILES  = accel_pkg::MAX_TILES,
    parameter int FIFO_DEPTH = accel_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        num_tiles,
    output logic [ADDR_W-1:0] addrO,
    output logic              renO,
    input  logic [DATA_W-1:0] dataO,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_tile_end,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int FW    = DATA_W + ADDR_W + 2;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CW + 1;
    localparam int TE_W  = $clog2(TILE_ELEMS);

    accel_pkg::drain_state_t state_r;

    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  total_r;
    logic [ADDR_W-1:0] addr_r;
    logic              ren_r;
    logic              busy_r;
    logic              done_r;
    logic              rvalid_r;
    logic [ADDR_W-1:0] ridx_r;

    logic [3:0]        n_s;
    logic [PTR_W-1:0]  total_s;
    logic              credit_s;
    logic              tile_end_s;
    logic              last_s;
    logic              pop_s;
    logic [FW-1:0]     push_data_s;
    logic [FW-1:0]     head_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // Run length and issue credit. Credit counts the read being issued now and the one
    // returning now, since the registered renO means both land before the decision is seen.
    always_comb begin
        n_s        = accel_pkg::clamp_tiles(num_tiles, 4'(MAX_TILES));
        total_s    = PTR_W'(n_s) * PTR_W'(TILE_ELEMS);
        credit_s   = !fifo_full_s &&
                     ((SUM_W'(fifo_count_s) + SUM_W'(rvalid_r) + SUM_W'(ren_r) + SUM_W'(1))
                      <= SUM_W'(FIFO_DEPTH));
        tile_end_s = &ridx_r[TE_W-1:0];
        last_s     = ({1'b0, ridx_r} == (total_r - PTR_W'(1)));
        push_data_s = {dataO, ridx_r, tile_end_s, last_s};
        pop_s      = !fifo_empty_s && m_ready;
    end

    // Drain FSM: issues reads under credit, then waits for the final beat to leave.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= accel_pkg::IDLE;
            rd_ptr_r <= {PTR_W{1'b0}};
            total_r  <= {PTR_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            ren_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            ren_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                accel_pkg::IDLE: begin
                    if (start) begin
                        total_r <= total_s;
                        if (n_s != 4'd0) begin
                            busy_r   <= 1'b1;
                            ren_r    <= 1'b1;
                            addr_r   <= {ADDR_W{1'b0}};
                            rd_ptr_r <= PTR_W'(1);
                            state_r  <= accel_pkg::ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= accel_pkg::DONE;
                        end
                    end else begin
                        state_r <= accel_pkg::IDLE;
                    end
                end
                accel_pkg::ISSUE: begin
                    if (rd_ptr_r == total_r) begin
                        state_r <= accel_pkg::FLUSH;
                    end else if (credit_s) begin
                        ren_r    <= 1'b1;
                        addr_r   <= rd_ptr_r[ADDR_W-1:0];
                        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                    end else begin
                        ren_r <= 1'b0;
                    end
                end
                accel_pkg::FLUSH: begin
                    if (pop_s && head_s[0]) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= accel_pkg::DONE;
                    end else begin
                        state_r <= accel_pkg::FLUSH;
                    end
                end
                accel_pkg::DONE: begin
                    state_r <= accel_pkg::IDLE;
                end
                default: begin
                    state_r <= accel_pkg::IDLE;
                end
            endcase
        end
    end

    // Read-return tracking: marks which address's data appears on dataO this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_r <= 1'b0;
            ridx_r   <= {ADDR_W{1'b0}};
        end else begin
            rvalid_r <= ren_r;
            ridx_r   <= addr_r;
        end
    end

    drain_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rvalid_r),
        .wdata (push_data_s),
        .pop   (pop_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign addrO      = addr_r;
    assign renO       = ren_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign m_valid    = !fifo_empty_s;
    assign m_data     = head_s[FW-1 -: DATA_W];
    assign m_index    = head_s[ADDR_W+1:2];
    assign m_tile_end = head_s[1];
    assign m_last     = head_s[0];

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain with a 1-cycle registered output-memory model (mem[i]=1000+i).
module tb_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_tiles;
    logic [6:0]  addrO;
    logic        renO;
    logic [31:0] dataO = 32'd0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [6:0]  m_index;
    logic        m_tile_end;
    logic        m_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] q_data[$];
    logic [6:0]  q_idx[$];
    logic        q_te[$];
    logic        q_last[$];
    int ren_cnt, done_cnt, done_cyc, first_valid_cyc, last_beat_cyc, stall_viol, stall_reads;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [6:0]  prev_idx;

    result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tiles  (num_tiles),
        .addrO      (addrO),
        .renO       (renO),
        .dataO      (dataO),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_tile_end (m_tile_end),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (renO) dataO <= 32'd1000 + 32'(addrO);
    end

    // Observe the stream half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (renO) ren_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_index !== prev_idx)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_idx.push_back(m_index);
                q_te.push_back(m_tile_end);
                q_last.push_back(m_last);
                last_beat_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_idx.delete();
        q_te.delete();
        q_last.delete();
        ren_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        last_beat_cyc = -1;
        stall_viol = 0;
        stall_reads = -1;
    endtask

    task automatic check_seq(input string tag, input int exp_n);
        int bad = 0;
        check_eq({tag, "_beats"}, q_data.size(), exp_n);
        foreach (q_data[i]) begin
            if (q_data[i] !== 32'(1000 + i) || q_idx[i] !== 7'(i) ||
                q_te[i] !== ((i % 16) == 15) || q_last[i] !== (i == exp_n - 1)) bad++;
        end
        check_eq({tag, "_order"}, bad, 0);
    endtask

    // mode 0: ready always high; 1: ready ~30% random; 2: ready low for 20 cycles then high.
    task automatic run_drain(input int nt, input int mode, input int restart_at, output int sc);
        clear_mon();
        @(posedge clk); #1;
        num_tiles = 4'(nt);
        start     = 1'b1;
        m_ready   = (mode == 0);
        sc        = cyc + 1;
        for (int k = 0; k < 800 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 9) < 3);
                default: m_ready = (k >= 20);
            endcase
            if (mode == 2 && k == 20) stall_reads = ren_cnt;
        end
        check_eq("done_seen", done_cnt, 1);
        start = 1'b0;
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int sc;
        rst = 1'b0;
        start = 1'b0;
        num_tiles = 4'd0;
        m_ready = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("init_busy", busy, 0);
        check_eq("init_valid", m_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Test 1: reset mid-stream, then a restart drains from index 0.
        clear_mon();
        @(posedge clk); #1;
        num_tiles = 4'd2; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("pre_rst_streaming", (q_data.size() > 0), 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_addrO", addrO, 0);
        check_eq("rst_renO", renO, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_index", m_index, 0);
        check_eq("rst_m_tile_end", m_tile_end, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("rst_no_done", done_cnt, 0);
        run_drain(1, 0, -1, sc);
        check_seq("restart", 16);

        // Test 2: single tile at full rate.
        run_drain(1, 0, -1, sc);
        check_seq("t1", 16);
        check_eq("t1_first_latency", first_valid_cyc - sc, 2);
        check_eq("t1_back_to_back", last_beat_cyc - first_valid_cyc, 15);
        check_eq("t1_done_latency", done_cyc - last_beat_cyc, 1);
        check_eq("t1_done_width", done_cnt, 1);
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_reads", ren_cnt, 16);

        // Test 3: full memory, final address 127 without wrap.
        run_drain(8, 0, -1, sc);
        check_seq("t8", 128);
        check_eq("t8_last_data", (q_data.size() == 128) ? q_data[127] : 32'd0, 1127);
        check_eq("t8_reads", ren_cnt, 128);

        // Test 4: random backpressure.
        run_drain(2, 1, -1, sc);
        check_seq("rand", 32);
        check_eq("rand_stall_stable", stall_viol, 0);
        check_eq("rand_reads", ren_cnt, 32);

        // Test 5: zero tiles, then an over-range request that clamps to 8.
        run_drain(0, 0, -1, sc);
        check_eq("zero_reads", ren_cnt, 0);
        check_eq("zero_beats", q_data.size(), 0);
        check_eq("zero_done_latency", done_cyc - sc, 0);
        run_drain(12, 0, -1, sc);
        check_seq("clamp", 128);

        // Test 6: second start during busy is dropped; stalled ready caps reads at the FIFO depth.
        run_drain(2, 0, 5, sc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_seq("restart_ignored", 32);
        check_eq("restart_ignored_done", done_cnt, 1);
        check_eq("restart_ignored_busy", busy, 0);
        run_drain(1, 2, -1, sc);
        check_eq("stall_reads", stall_reads, 4);
        check_seq("stall", 16);
        check_eq("stall_hold", stall_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
